// File: rtl/usb_wr_arb.sv
// Round-robin arbiter sharing the USB write FIFO between NUM_SRC 32-bit sources, committing
// packets on burst end, idle timeout or CPU request. Optional stall counter: USB_WR_ARB_STALL_CNT_EN.
module usb_wr_arb #(
    parameter int NUM_SRC       = 4,
    parameter int BURST_LEN     = 64,
    parameter int FLUSH_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    src_en,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [32*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]    src_ready,
    output logic [31:0]           usb_wr_data,
    output logic [3:0]            usb_wr_be,
    output logic                  usb_wr_en,
    input  logic                  usb_wr_fifo_full,
    output logic                  usb_wr_push,
    input  logic                  cpu_push,
    output logic [1:0]            cur_src,
`ifdef USB_WR_ARB_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_PUSH  = 2'd2
    } state_t;

    localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);
    localparam logic [19:0] TMO_LAST   = 20'(FLUSH_TIMEOUT - 1);
    localparam logic [1:0]  RR_INIT    = 2'(NUM_SRC - 1);

    state_t       state_q, state_d;
    logic [1:0]   rr_q, rr_d;
    logic [1:0]   cur_src_q, cur_src_d;
    logic [15:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0]  pending_q, pending_d;
    logic [19:0]  tmo_q, tmo_d;
    logic         cpu_lat_q, cpu_lat_d;
    logic         wr_en_q, wr_en_d;
    logic [3:0]   wr_be_q, wr_be_d;
    logic [31:0]  wr_data_q, wr_data_d;
    logic         push_q, push_d;
    logic         busy_q, busy_d;

    logic [NUM_SRC-1:0] eligible_s;
    logic               grant_vld_s;
    logic [1:0]         grant_idx_s;
    logic [1:0]         cand_s;
    logic [31:0]        cur_word_s;
    logic               cur_valid_s;
    logic               cur_en_s;
    logic               xfer_s;

    // Round-robin pick: walk downwards so the source closest after rr_q is assigned last
    always_comb begin
        eligible_s  = src_valid & src_en;
        grant_vld_s = 1'b0;
        grant_idx_s = 2'd0;
        cand_s      = 2'd0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand_s = 2'((int'(rr_q) + k) % NUM_SRC);
            if (eligible_s[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Granted-source view and handshake
    always_comb begin
        cur_word_s = 32'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cur_word_s = (cur_src_q == 2'(i)) ? src_data[32*i +: 32] : cur_word_s;
        end
        cur_valid_s = src_valid[cur_src_q];
        cur_en_s    = src_en[cur_src_q];
        xfer_s      = (state_q == ST_BURST) && cur_en_s && cur_valid_s && !usb_wr_fifo_full;
        src_ready            = {NUM_SRC{1'b0}};
        src_ready[cur_src_q] = (state_q == ST_BURST) && cur_en_s && !usb_wr_fifo_full;
    end

    // Next-state logic for the arbiter FSM and its registered outputs
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cur_src_d   = cur_src_q;
        burst_cnt_d = burst_cnt_q;
        pending_d   = pending_q;
        tmo_d       = tmo_q;
        cpu_lat_d   = cpu_lat_q | cpu_push;
        wr_en_d     = xfer_s;
        wr_be_d     = xfer_s ? 4'hF : 4'h0;
        wr_data_d   = xfer_s ? cur_word_s : wr_data_q;
        push_d      = (state_q == ST_PUSH);
        if (xfer_s) begin
            tmo_d     = 20'd0;
            pending_d = (pending_q == 16'hFFFF) ? pending_q : pending_q + 16'd1;
        end else begin
            pending_d = pending_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (cpu_lat_q || ((pending_q != 16'd0) && (tmo_q == TMO_LAST))) begin
                    state_d = ST_PUSH;
                end else if (grant_vld_s) begin
                    state_d     = ST_BURST;
                    cur_src_d   = grant_idx_s;
                    rr_d        = grant_idx_s;
                    burst_cnt_d = 16'd0;
                end else if (pending_q != 16'd0) begin
                    tmo_d = tmo_q + 20'd1;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            ST_BURST: begin
                if (xfer_s) begin
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    state_d     = (burst_cnt_q == BURST_LAST) ? ST_PUSH : ST_BURST;
                end else if (!usb_wr_fifo_full && !(cur_valid_s && cur_en_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_PUSH: begin
                // A cpu_push arriving during the commit is absorbed into it
                pending_d = 16'd0;
                tmo_d     = 20'd0;
                cpu_lat_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Arbiter state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rr_q        <= RR_INIT;
            cur_src_q   <= 2'd0;
            burst_cnt_q <= 16'd0;
            pending_q   <= 16'd0;
            tmo_q       <= 20'd0;
            cpu_lat_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_be_q     <= 4'h0;
            wr_data_q   <= 32'd0;
            push_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cur_src_q   <= cur_src_d;
            burst_cnt_q <= burst_cnt_d;
            pending_q   <= pending_d;
            tmo_q       <= tmo_d;
            cpu_lat_q   <= cpu_lat_d;
            wr_en_q     <= wr_en_d;
            wr_be_q     <= wr_be_d;
            wr_data_q   <= wr_data_d;
            push_q      <= push_d;
            busy_q      <= busy_d;
        end
    end

    assign usb_wr_en   = wr_en_q;
    assign usb_wr_be   = wr_be_q;
    assign usb_wr_data = wr_data_q;
    assign usb_wr_push = push_q;
    assign cur_src     = cur_src_q;
    assign busy        = busy_q;

`ifdef USB_WR_ARB_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Stall accounting: granted source waiting on a full FIFO
    always_comb begin
        if (cpu_push) begin
            stall_d = 32'd0;
        end else if ((state_q == ST_BURST) && cur_valid_s && usb_wr_fifo_full &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
